// File: rtl/regfile_dump_ctrl.sv
// Register file dump engine: freezes the core, drains, streams every regfile word.
// Optional REGDUMP_CHECKSUM_EN appends an XOR checksum word after the last register.
module regfile_dump_ctrl #(
    parameter int DATAPATH_WIDTH     = 64,
    parameter int REGFILE_ADDR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          pipe_empty,
    output logic                          freeze_out,
    output logic [REGFILE_ADDR_WIDTH-1:0] rd_addr_out,
    input  logic [DATAPATH_WIDTH-1:0]     rd_data_in,
    output logic [DATAPATH_WIDTH-1:0]     dout_data,
    output logic                          dout_valid,
    output logic                          dout_last,
    input  logic                          dout_ready,
    output logic                          busy,
    output logic                          done
);

    localparam logic [REGFILE_ADDR_WIDTH-1:0] MAX = '1;

`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_READ, S_SEND, S_CSUM, S_FIN
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_READ, S_SEND, S_FIN
    } state_t;
`endif

    state_t                          r_state;
    state_t                          w_next;
    logic [REGFILE_ADDR_WIDTH-1:0]   r_idx;
    logic [DATAPATH_WIDTH-1:0]       r_data;
    logic                            r_valid;
    logic                            r_last;
    logic                            r_freeze;
    logic                            w_hs;
    logic                            w_abort;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATAPATH_WIDTH-1:0]       r_csum;
`endif

    assign w_hs        = r_valid && dout_ready;
    assign w_abort     = abort && (r_state != S_IDLE);
    assign rd_addr_out = r_idx;
    assign dout_data   = r_data;
    assign dout_valid  = r_valid;
    assign dout_last   = r_last;
    assign freeze_out  = r_freeze;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_FIN) && !abort;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (start) w_next = S_DRAIN;
                S_DRAIN: if (pipe_empty) w_next = S_READ;
                S_READ:  w_next = S_SEND;
                S_SEND: begin
                    if (w_hs) begin
`ifdef REGDUMP_CHECKSUM_EN
                        w_next = (r_idx == MAX) ? S_CSUM : S_READ;
`else
                        w_next = (r_idx == MAX) ? S_FIN : S_READ;
`endif
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                S_CSUM:  if (w_hs) w_next = S_FIN;
`endif
                S_FIN:   w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Datapath: index walk, output word register, freeze and checksum
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_freeze <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            r_csum   <= '0;
`endif
        end else if (w_abort) begin
            r_idx    <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_freeze <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_freeze <= 1'b1;
                        r_idx    <= '0;
`ifdef REGDUMP_CHECKSUM_EN
                        r_csum   <= '0;
`endif
                    end
                end
                S_READ: begin
                    r_data  <= rd_data_in;
                    r_valid <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                    r_last  <= 1'b0;
                    r_csum  <= r_csum ^ rd_data_in;
`else
                    r_last  <= (r_idx == MAX);
`endif
                end
                S_SEND: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        if (r_idx != MAX) begin
                            r_idx <= r_idx + 1'b1;
                        end else begin
`ifdef REGDUMP_CHECKSUM_EN
                            r_data  <= r_csum;
                            r_valid <= 1'b1;
                            r_last  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (w_hs) r_valid <= 1'b0;
                end
`endif
                S_FIN: begin
                    r_freeze <= 1'b0;
                    r_idx    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
